fx2_fft_dout_tx: RTL and testbench
==================================

Name: fx2_fft_dout_tx

Overview:
Transmit path from the FFT core to the host over the CY7C68013 (FX2) slave FIFO in synchronous mode.
- Accepts one complete FFT result frame (2**NPOINT complex points, parallel vectors) through a valid/busy handshake.
- Serialises the frame into 16-bit words and writes them to the IN endpoint FIFO, honouring the FX2 full flag.
- Commits each frame with PKTEND.
- Shares the FX2 data bus with the receive-side interface through a request/grant pair. The top level owns the tristate on fx2_db.

Parameters:
NPOINT, 3, log2 of FFT points; frame = 2**NPOINT complex points = 2*(2**NPOINT) words
DW, 16, sample width (real and imag each); must equal the FX2 bus width 16
EP_ADDR, 2'b10, FIFOADR value selecting the IN endpoint (EP6)
PKTEND_EN, 1, 1 = pulse pktend after each frame; 0 = skip the PKTEND state

Ports:
clk  in  1  system clock, same clock as FX2 IFCLK domain
rst_n  in  1  asynchronous, active-low reset
fft_dout_valid  in  1  frame available on fft_dout_real/imag
fft_dout_busy  out  1  high while a frame is held or being sent; producer must hold while high
fft_dout_real  in  DW*2**NPOINT  point k at bits [DW*k +: DW]
fft_dout_imag  in  DW*2**NPOINT  point k at bits [DW*k +: DW]
tx_req  out  1  bus request to the receive/transmit arbiter
tx_gnt  in  1  bus granted; arbiter holds it until tx_req drops
fx2_full_n  in  1  IN FIFO full flag, active low (1 = space available)
fx2_slcs_n  out  1  chip select, low while granted
fx2_slwr_n  out  1  write strobe, active low
fx2_pktend_n  out  1  packet end strobe, active low
fx2_a  out  2  FIFO address
fx2_db_out  out  16  write data
fx2_db_oe  out  1  1 = top level drives fx2_db from fx2_db_out
frame_cnt  out  16  frames completed, wraps 0xFFFF->0

Behaviour:
- Reset values:
  - fft_dout_busy 0, tx_req 0
  - fx2_slcs_n 1, fx2_slwr_n 1, fx2_pktend_n 1
  - fx2_a 2'b00, fx2_db_out 0, fx2_db_oe 0
  - frame_cnt 0, state IDLE, word index 0
- Reset mid-frame:
  - Aborts immediately to the reset values.
  - The partial packet is abandoned with no PKTEND.
- States:
  - IDLE:
    - busy=0.
    - If fft_dout_valid=1 at a clock edge, capture both vectors into the frame register, set busy=1 and go to REQ.
  - REQ:
    - tx_req=1; wait for tx_gnt=1.
    - Then go to SETUP.
  - SETUP (1 cycle):
    - slcs_n=0, fx2_a=EP_ADDR, db_oe=1, db_out=word 0, slwr_n=1.
    - Provides address setup time.
  - WRITE:
    - fx2_slwr_n = ~(state==WRITE && fx2_full_n). This is combinational from the flag, so a word is never written into a full FIFO.
    - At each edge where slwr_n is low, advance the word index and load the next word into db_out.
    - While fx2_full_n=0, hold the index and data; no drop, no duplicate.
    - After the last word (index 2*2**NPOINT-1) is written, go to PKTEND, or to DONE if PKTEND_EN=0.
  - PKTEND (1 cycle):
    - fx2_pktend_n=0, slwr_n=1, address still EP_ADDR.
  - DONE (1 cycle):
    - Drop tx_req, slcs_n=1, db_oe=0.
    - Increment frame_cnt; busy=0 at the next edge; return to IDLE.
- Word order: real[0], imag[0], real[1], imag[1], ... real[N-1], imag[N-1]. Words are raw 16-bit two's complement, no reformatting.
- fft_dout_valid while busy=1 is ignored (not queued). A new frame is accepted at the first edge in IDLE where valid=1, so the earliest accept is the edge after DONE.
- Deassertion of tx_gnt while tx_req=1 is a protocol error and is ignored.
- fx2_a returns to 2'b00 in IDLE/REQ.
- Minimum frame time with no backpressure and immediate grant: REQ 1 + SETUP 1 + WRITE 2N + PKTEND 1 + DONE 1 cycles.

Decomposition:
- Shared package fx2_pkg holds:
  - FX2 FIFOADR constants (EP2/EP4/EP6/EP8).
  - The state enum of this block, alongside the receive-side mode encodings.
  - The function words_per_frame(NPOINT).
- Natural sub-module: fft_frame_serializer. It holds the frame register, word index and word mux, with ports load/advance/last.
- The FSM and FX2 strobes stay in the top of this block.

Test Plan:
1. NPOINT=3, real[k]=0x1000+k, imag[k]=0x2000+k, tx_gnt tied 1, full_n=1 -> 16 consecutive slwr_n-low cycles carrying 0x1000,0x2000,0x1001,...,0x1007,0x2007; then one pktend_n pulse; busy high 20 cycles; frame_cnt=1.
2. Same frame, full_n=0 for 5 cycles starting after 3 words written -> no strobe during those 5 cycles; 4th word 0x2001 written once when full_n returns; 16 words total; busy high 25 cycles.
3. tx_gnt held 0 for 10 cycles after valid -> tx_req=1, slcs_n=1, db_oe=0 throughout; transfer starts with SETUP the cycle after grant.
4. Second valid pulse with different data while busy -> ignored; only the first frame appears; frame_cnt=1.
5. rst_n asserted after 7 words written -> next cycle all outputs at reset values, no pktend; a fresh frame afterwards is sent from word 0.
6. PKTEND_EN=0, two back-to-back frames with valid held high -> no pktend_n pulses; second frame accepted at the edge after the first DONE; frame_cnt=2.

Source files
------------

// File: rtl/fx2_pkg.sv
// Shared FX2 slave-FIFO definitions: endpoint addresses, transmit FSM state
// encodings, receive-side mode encodings and frame sizing helper.
package fx2_pkg;

   localparam logic [1:0] FX2_EP2 = 2'b00;
   localparam logic [1:0] FX2_EP4 = 2'b01;
   localparam logic [1:0] FX2_EP6 = 2'b10;
   localparam logic [1:0] FX2_EP8 = 2'b11;

   typedef logic [2:0] tx_state_t;

   localparam tx_state_t TX_IDLE   = 3'd0;
   localparam tx_state_t TX_REQ    = 3'd1;
   localparam tx_state_t TX_SETUP  = 3'd2;
   localparam tx_state_t TX_WRITE  = 3'd3;
   localparam tx_state_t TX_PKTEND = 3'd4;
   localparam tx_state_t TX_DONE   = 3'd5;

   typedef enum logic [1:0] {
      RX_MODE_IDLE = 2'd0,
      RX_MODE_CMD  = 2'd1,
      RX_MODE_DATA = 2'd2
   } rx_mode_e;

   // One real and one imaginary word per FFT point.
   function automatic int unsigned words_per_frame(input int unsigned npoint);
      return 2 * (32'd1 << npoint);
   endfunction

endpackage

// File: rtl/fx2_fft_dout_tx_serializer.sv
// Frame register plus word index/mux that flattens a captured FFT frame into
// the interleaved real/imag word stream.
module fft_frame_serializer
   import fx2_pkg::*;
#(
   parameter int NPOINT = 3,
   parameter int DW     = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        load_i,
   input  logic [DW*(2**NPOINT)-1:0]   real_i,
   input  logic [DW*(2**NPOINT)-1:0]   imag_i,
   input  logic                        advance_i,
   output logic signed [DW-1:0]        word_o,
   output logic                        last_o
);

   localparam int NPT   = 2**NPOINT;
   localparam int WORDS = int'(words_per_frame(NPOINT));
   localparam int IW    = $clog2(WORDS);
   localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

   logic [DW*NPT-1:0] real_q;
   logic [DW*NPT-1:0] imag_q;
   logic [IW-1:0]     idx_q;
   logic [IW-1:0]     idx_d;
   logic [NPOINT-1:0] pt;

   // Sample storage carries no reset; only the index is control state.
   always_ff @(posedge clk) begin
      if (load_i) begin
         real_q <= real_i;
         imag_q <= imag_i;
      end
   end

   // Index wraps to zero naturally after the last word of the frame.
   always_comb begin
      idx_d = idx_q;
      if (load_i) begin
         idx_d = '0;
      end else if (advance_i) begin
         idx_d = idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

   assign pt     = idx_q[IW-1:1];
   assign word_o = idx_q[0] ? $signed(imag_q[DW*pt +: DW]) : $signed(real_q[DW*pt +: DW]);
   assign last_o = (idx_q == LAST_IDX);

endmodule

// File: rtl/fx2_fft_dout_tx.sv
// FFT result frame transmitter onto the FX2 synchronous slave-FIFO IN endpoint,
// with bus arbitration against the receive side and optional PKTEND commit.
module fx2_fft_dout_tx
   import fx2_pkg::*;
#(
   parameter int         NPOINT    = 3,
   parameter int         DW        = 16,
   parameter logic [1:0] EP_ADDR   = FX2_EP6,
   parameter bit         PKTEND_EN = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        fft_dout_valid,
   output logic                        fft_dout_busy,
   input  logic [DW*(2**NPOINT)-1:0]   fft_dout_real,
   input  logic [DW*(2**NPOINT)-1:0]   fft_dout_imag,
   output logic                        tx_req,
   input  logic                        tx_gnt,
   input  logic                        fx2_full_n,
   output logic                        fx2_slcs_n,
   output logic                        fx2_slwr_n,
   output logic                        fx2_pktend_n,
   output logic [1:0]                  fx2_a,
   output logic [15:0]                 fx2_db_out,
   output logic                        fx2_db_oe,
   output logic [15:0]                 frame_cnt
);

   tx_state_t state_q;
   tx_state_t state_d;
   logic [15:0] frame_cnt_q;
   logic [15:0] frame_cnt_d;
   logic        load;
   logic        advance;
   logic        last;
   logic        on_bus;
   logic signed [DW-1:0] word;

   fft_frame_serializer #(
      .NPOINT (NPOINT),
      .DW     (DW)
   ) u_ser (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (load),
      .real_i    (fft_dout_real),
      .imag_i    (fft_dout_imag),
      .advance_i (advance),
      .word_o    (word),
      .last_o    (last)
   );

   // A grant that drops mid-transfer is deliberately not looked at after REQ.
   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      load        = 1'b0;
      advance     = 1'b0;
      case (state_q)
         TX_IDLE: begin
            if (fft_dout_valid) begin
               load    = 1'b1;
               state_d = TX_REQ;
            end
         end
         TX_REQ: begin
            if (tx_gnt) begin
               state_d = TX_SETUP;
            end
         end
         TX_SETUP: begin
            state_d = TX_WRITE;
         end
         TX_WRITE: begin
            if (fx2_full_n) begin
               advance = 1'b1;
               if (last) begin
                  state_d = PKTEND_EN ? TX_PKTEND : TX_DONE;
               end
            end
         end
         TX_PKTEND: begin
            state_d = TX_DONE;
         end
         TX_DONE: begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = TX_IDLE;
         end
         default: begin
            state_d = TX_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= TX_IDLE;
         frame_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Write strobe follows the full flag combinationally so a full FIFO is never written.
   assign on_bus        = (state_q == TX_SETUP) || (state_q == TX_WRITE) || (state_q == TX_PKTEND);
   assign fft_dout_busy = (state_q != TX_IDLE);
   assign tx_req        = on_bus || (state_q == TX_REQ);
   assign fx2_slcs_n    = ~on_bus;
   assign fx2_slwr_n    = ~((state_q == TX_WRITE) && fx2_full_n);
   assign fx2_pktend_n  = ~(state_q == TX_PKTEND);
   assign fx2_a         = on_bus ? EP_ADDR : 2'b00;
   assign fx2_db_oe     = on_bus;
   assign fx2_db_out    = on_bus ? 16'(word) : 16'd0;
   assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_fx2_fft_dout_tx.sv
// Bench for fx2_fft_dout_tx: table of frame scenarios plus hand-written reset
// and back-to-back sequences, with per-word scoreboards on both instances.
module tb_fx2_fft_dout_tx;

   localparam int NP = 3;
   localparam int NPT = 2**NP;
   localparam int VW = 16*NPT;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          valid0, busy0, req0, gnt0, full0, slcs0, slwr0, pkt0, oe0;
   logic [VW-1:0] re0, im0;
   logic [1:0]    a0;
   logic [15:0]   db0, fc0;

   logic          valid1, busy1, req1, gnt1, full1, slcs1, slwr1, pkt1, oe1;
   logic [VW-1:0] re1, im1;
   logic [1:0]    a1;
   logic [15:0]   db1, fc1;

   fx2_fft_dout_tx #(.NPOINT(NP), .DW(16), .EP_ADDR(2'b10), .PKTEND_EN(1'b1)) dut0 (
      .clk(clk), .rst_n(rst_n), .fft_dout_valid(valid0), .fft_dout_busy(busy0),
      .fft_dout_real(re0), .fft_dout_imag(im0), .tx_req(req0), .tx_gnt(gnt0),
      .fx2_full_n(full0), .fx2_slcs_n(slcs0), .fx2_slwr_n(slwr0), .fx2_pktend_n(pkt0),
      .fx2_a(a0), .fx2_db_out(db0), .fx2_db_oe(oe0), .frame_cnt(fc0));

   fx2_fft_dout_tx #(.NPOINT(NP), .DW(16), .EP_ADDR(2'b10), .PKTEND_EN(1'b0)) dut1 (
      .clk(clk), .rst_n(rst_n), .fft_dout_valid(valid1), .fft_dout_busy(busy1),
      .fft_dout_real(re1), .fft_dout_imag(im1), .tx_req(req1), .tx_gnt(gnt1),
      .fx2_full_n(full1), .fx2_slcs_n(slcs1), .fx2_slwr_n(slwr1), .fx2_pktend_n(pkt1),
      .fx2_a(a1), .fx2_db_out(db1), .fx2_db_oe(oe1), .frame_cnt(fc1));

   typedef struct {
      logic [15:0] re_base;
      logic [15:0] im_base;
      int          gnt_wait;
      int          stall_after;
      int          stall_len;
      int          extra_at;
      int          exp_busy;
   } frame_t;

   int tests = 0;
   int fails = 0;
   logic [15:0] q0[$];
   logic [15:0] q1[$];
   int wr_seen0 = 0, pk_seen0 = 0, wr_seen1 = 0, pk_seen1 = 0;
   int exp_fc0 = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic build(input logic [15:0] rb, input logic [15:0] ib,
                        output logic [VW-1:0] rv, output logic [VW-1:0] iv);
      for (int k = 0; k < NPT; k++) begin
         rv[16*k +: 16] = rb + 16'(k);
         iv[16*k +: 16] = ib + 16'(k);
      end
   endtask

   // One clock: sample both DUTs at the falling edge and run the scoreboards.
   task automatic cyc();
      @(negedge clk);
      if (slwr0 === 1'b0) begin
         wr_seen0++;
         check("dut0_full_respected", 32'(full0), 32'd1);
         if (q0.size() == 0) begin
            tests++; fails++;
            $display("FAIL dut0_unexpected_write: got 0x%0h, expected no write", db0);
         end else begin
            check("dut0_word", 32'(db0), 32'(q0.pop_front()));
         end
      end
      if (pkt0 === 1'b0) begin
         pk_seen0++;
         check("dut0_pktend_slwr", 32'(slwr0), 32'd1);
         check("dut0_pktend_addr", 32'(a0), 32'h2);
      end
      if (slwr1 === 1'b0) begin
         wr_seen1++;
         if (q1.size() == 0) begin
            tests++; fails++;
            $display("FAIL dut1_unexpected_write: got 0x%0h, expected no write", db1);
         end else begin
            check("dut1_word", 32'(db1), 32'(q1.pop_front()));
         end
      end
      if (pkt1 === 1'b0) pk_seen1++;
   endtask

   task automatic check_reset0(input string tag);
      check({tag, "_busy"},   32'(busy0), 32'd0);
      check({tag, "_txreq"},  32'(req0),  32'd0);
      check({tag, "_slcs"},   32'(slcs0), 32'd1);
      check({tag, "_slwr"},   32'(slwr0), 32'd1);
      check({tag, "_pktend"}, 32'(pkt0),  32'd1);
      check({tag, "_addr"},   32'(a0),    32'd0);
      check({tag, "_dbout"},  32'(db0),   32'd0);
      check({tag, "_dboe"},   32'(oe0),   32'd0);
      check({tag, "_fcnt"},   32'(fc0),   32'd0);
   endtask

   task automatic run_frame(input frame_t r, input string tag);
      int busy_n, wr_base, pk_base, stall_left, c;
      bit stall_started, req_ok, done;
      logic [VW-1:0] rv, iv;
      build(r.re_base, r.im_base, rv, iv);
      for (int k = 0; k < NPT; k++) begin
         q0.push_back(rv[16*k +: 16]);
         q0.push_back(iv[16*k +: 16]);
      end
      re0 = rv; im0 = iv; valid0 = 1'b1; full0 = 1'b1;
      gnt0 = (r.gnt_wait == 0);
      wr_base = wr_seen0; pk_base = pk_seen0;
      busy_n = 0; stall_left = 0; stall_started = 0; req_ok = 1; done = 0;
      for (c = 1; c <= 200; c++) begin
         cyc();
         if (!busy0) begin
            done = 1;
            break;
         end
         busy_n++;
         if (c == 1) valid0 = 1'b0;
         if (c <= r.gnt_wait + 1) begin
            if (!(req0 === 1'b1 && slcs0 === 1'b1 && oe0 === 1'b0 && a0 === 2'b00))
               req_ok = 0;
         end
         if (c == r.gnt_wait + 2) begin
            check({tag, "_setup_slcs"}, 32'(slcs0), 32'd0);
            check({tag, "_setup_slwr"}, 32'(slwr0), 32'd1);
            check({tag, "_setup_addr"}, 32'(a0),    32'h2);
            check({tag, "_setup_oe"},   32'(oe0),   32'd1);
            check({tag, "_setup_word"}, 32'(db0),   32'(r.re_base));
         end
         gnt0 = (c >= r.gnt_wait + 1);
         if (r.extra_at != 0 && c == r.extra_at) begin
            build(16'h7000, 16'h7100, rv, iv);
            re0 = rv; im0 = iv; valid0 = 1'b1;
         end else if (r.extra_at != 0 && c == r.extra_at + 1) begin
            valid0 = 1'b0;
         end
         if (!stall_started && r.stall_len > 0 && (wr_seen0 - wr_base) == r.stall_after) begin
            stall_started = 1;
            stall_left = r.stall_len;
         end
         if (stall_left > 0) begin
            full0 = 1'b0;
            stall_left--;
         end else begin
            full0 = 1'b1;
         end
      end
      if (!done) begin
         tests++; fails++;
         $display("FAIL %s_timeout: busy still high after %0d cycles, expected low", tag, c);
      end
      gnt0 = 1'b0; full0 = 1'b1; valid0 = 1'b0;
      exp_fc0++;
      check({tag, "_req_phase"},   32'(req_ok), 32'd1);
      check({tag, "_busy_cycles"}, 32'(busy_n), 32'(r.exp_busy));
      check({tag, "_words"},       32'(wr_seen0 - wr_base), 32'd16);
      check({tag, "_pktends"},     32'(pk_seen0 - pk_base), 32'd1);
      check({tag, "_frame_cnt"},   32'(fc0), 32'(exp_fc0));
      check({tag, "_sb_empty"},    32'(q0.size()), 32'd0);
   endtask

   frame_t tbl[4];

   initial begin
      int n, run1, gap, phase;
      logic [VW-1:0] rv, iv;
      tbl[0] = '{16'h1000, 16'h2000, 0,  0, 0, 0, 20};
      tbl[1] = '{16'h1000, 16'h2000, 0,  3, 5, 0, 25};
      tbl[2] = '{16'h1100, 16'h2100, 10, 0, 0, 0, 30};
      tbl[3] = '{16'h1200, 16'h2200, 0,  0, 0, 5, 20};

      rst_n = 1'b0;
      valid0 = 0; gnt0 = 0; full0 = 1; re0 = '0; im0 = '0;
      valid1 = 0; gnt1 = 0; full1 = 1; re1 = '0; im1 = '0;
      cyc(); cyc();
      check_reset0("rst");
      rst_n = 1'b1;
      cyc();

      foreach (tbl[i]) begin
         run_frame(tbl[i], $sformatf("row%0d", i));
         cyc();
      end

      // Reset in the middle of a frame: abandon it, no PKTEND, then resend cleanly.
      build(16'h3000, 16'h4000, rv, iv);
      for (int k = 0; k < NPT; k++) begin
         q0.push_back(rv[16*k +: 16]);
         q0.push_back(iv[16*k +: 16]);
      end
      re0 = rv; im0 = iv; valid0 = 1'b1; gnt0 = 1'b1; full0 = 1'b1;
      n = wr_seen0;
      for (int c = 0; c < 100 && (wr_seen0 - n) < 7; c++) begin
         cyc();
         valid0 = 1'b0;
      end
      check("midrst_words_before", 32'(wr_seen0 - n), 32'd7);
      n = pk_seen0;
      rst_n = 1'b0;
      gnt0 = 1'b0;
      cyc();
      check_reset0("midrst");
      check("midrst_no_pktend", 32'(pk_seen0 - n), 32'd0);
      q0.delete();
      exp_fc0 = 0;
      rst_n = 1'b1;
      cyc();
      run_frame(tbl[0], "after_rst");
      cyc();

      // PKTEND disabled, valid held high across two back-to-back frames.
      build(16'h5000, 16'h6000, rv, iv);
      for (int k = 0; k < NPT; k++) begin
         q1.push_back(rv[16*k +: 16]);
         q1.push_back(iv[16*k +: 16]);
      end
      re1 = rv; im1 = iv; valid1 = 1'b1; gnt1 = 1'b1; full1 = 1'b1;
      cyc();
      build(16'h5100, 16'h6100, rv, iv);
      for (int k = 0; k < NPT; k++) begin
         q1.push_back(rv[16*k +: 16]);
         q1.push_back(iv[16*k +: 16]);
      end
      re1 = rv; im1 = iv;
      run1 = 0; gap = 0; phase = 0;
      for (int c = 0; c < 100 && phase < 3; c++) begin
         if (phase == 0) begin
            if (busy1) run1++; else begin phase = 1; gap = 1; end
         end else if (phase == 1) begin
            if (!busy1) gap++; else begin phase = 2; valid1 = 1'b0; end
         end else if (!busy1) begin
            phase = 3;
         end
         if (phase < 3) cyc();
      end
      valid1 = 1'b0; gnt1 = 1'b0;
      check("b2b_finished",  32'(phase), 32'd3);
      check("b2b_first_len", 32'(run1), 32'd19);
      check("b2b_gap",       32'(gap), 32'd1);
      check("b2b_words",     32'(wr_seen1), 32'd32);
      check("b2b_pktends",   32'(pk_seen1), 32'd0);
      check("b2b_frame_cnt", 32'(fc1), 32'd2);
      check("b2b_sb_empty",  32'(q1.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
